// File: rtl/life_sequencer.sv
// rtl/life_sequencer.sv - seed/step/halt sequencer for the 8x8 Game-of-Life grid datapath
module life_sequencer #(
  parameter int unsigned STEP_DIV  = 1,
  parameter int unsigned GEN_W     = 16,
  parameter int unsigned MAX_GEN   = 0,
  parameter logic [63:0] LFSR_SEED = 64'hACE1_2468_1357_BDF9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             randomize,
  input  logic [63:0]      grid_cur,
  input  logic [63:0]      grid_next,
  output logic [63:0]      seed,
  output logic             seed_en,
  output logic             step_en,
  output logic [GEN_W-1:0] gen_count,
  output logic             running,
  output logic             stable,
  output logic             extinct
);

  localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  // Galois right shift: taps 64,63,61,60 land on bits 63,62,60,59
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      lfsr_d, lfsr_nxt;
  logic [GEN_W-1:0] gen_d, gen_inc;
  logic [DIV_W-1:0] div_q, div_d;
  logic             stable_d, extinct_d;
  logic             seed_en_d, step_en_d, running_d;
  logic             halt;

  assign lfsr_nxt = {1'b0, seed[63:1]} ^ (seed[0] ? LFSR_TAPS : 64'd0);
  assign gen_inc  = (&gen_count) ? gen_count : gen_count + GEN_W'(1);

  always_comb begin
    state_d   = state_q;
    lfsr_d    = seed;
    gen_d     = gen_count;
    div_d     = div_q;
    stable_d  = stable;
    extinct_d = extinct;
    halt      = 1'b0;

    case (state_q)
      IDLE: begin
        if (randomize)  state_d = SEED;
        else if (start) state_d = RUN;
      end
      SEED: begin
        lfsr_d = lfsr_nxt;
        if (!randomize) state_d = start ? RUN : IDLE;
      end
      RUN: begin
        div_d = step_en ? '0 : div_q + DIV_W'(1);
        // A step already in flight on this edge is always accounted for,
        // even when start or randomize also moves the state away.
        if (step_en) begin
          gen_d = gen_inc;
          if (grid_next == 64'd0) begin
            extinct_d = 1'b1;
            halt      = 1'b1;
          end else if (grid_next == grid_cur) begin
            stable_d = 1'b1;
            halt     = 1'b1;
          end else if ((MAX_GEN != 0) && (gen_inc == GEN_W'(MAX_GEN))) begin
            halt = 1'b1;
          end
        end
        if (randomize)   state_d = SEED;
        else if (!start) state_d = IDLE;
        else if (halt)   state_d = DONE;
      end
      DONE: begin
        if (randomize)   state_d = SEED;
        else if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == SEED) && (state_q != SEED)) begin
      gen_d     = '0;
      stable_d  = 1'b0;
      extinct_d = 1'b0;
    end
    if ((state_d == RUN) && (state_q != RUN)) begin
      div_d     = '0;
      stable_d  = 1'b0;
      extinct_d = 1'b0;
    end

    seed_en_d = (state_d == SEED);
    running_d = (state_d == RUN);
    step_en_d = (state_d == RUN) && (div_d == DIV_W'(STEP_DIV - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      seed      <= LFSR_SEED;
      gen_count <= '0;
      div_q     <= '0;
      stable    <= 1'b0;
      extinct   <= 1'b0;
      seed_en   <= 1'b0;
      step_en   <= 1'b0;
      running   <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed      <= lfsr_d;
      gen_count <= gen_d;
      div_q     <= div_d;
      stable    <= stable_d;
      extinct   <= extinct_d;
      seed_en   <= seed_en_d;
      step_en   <= step_en_d;
      running   <= running_d;
    end
  end

endmodule

// File: doc/life_sequencer.md
Name: life_sequencer

Overview:
Control sequencer for the 8x8 Game-of-Life grid datapath, which holds a 64-bit grid state and computes the next generation combinationally.
- Seeds the grid from an internal 64-bit LFSR while randomize is held.
- Paces generation steps at a programmable rate while start is held.
- Counts generations and halts on a stable pattern, on extinction, or on reaching a generation limit.

Parameters:
STEP_DIV, 1, clock cycles per generation step (>=1)
GEN_W, 16, width of the generation counter
MAX_GEN, 0, generation limit; 0 = unlimited
LFSR_SEED, 64'hACE1_2468_1357_BDF9, LFSR reset value (must be nonzero)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-low reset
start  in  1  level: run generations while high
randomize  in  1  level: seed grid while high; has priority over start
grid_cur  in  64  current grid from datapath; row r = bits [8r+7:8r]
grid_next  in  64  datapath's combinational next generation
seed  out  64  LFSR pattern for datapath to load
seed_en  out  1  datapath loads seed on this edge
step_en  out  1  datapath loads grid_next on this edge
gen_count  out  GEN_W  generations stepped since last seed/restart
running  out  1  high in RUN
stable  out  1  sticky: last step produced an unchanged grid
extinct  out  1  sticky: last step produced an empty grid

Behaviour:
- Reset (reset=0, async):
  - State = IDLE; seed = LFSR_SEED.
  - seed_en, step_en, running, stable, extinct = 0; gen_count = 0; divider = 0.
- All outputs are registered.
- States: IDLE, SEED, RUN, DONE.
- IDLE:
  - randomize=1 -> SEED.
  - else start=1 -> RUN; stable and extinct clear on entry.
  - gen_count is held, so a paused run resumes counting.
- SEED:
  - On entry, gen_count, stable and extinct clear.
  - seed_en=1 in every SEED cycle; LFSR advances once per cycle.
  - LFSR is a 64-bit Galois shift right, taps 64,63,61,60.
  - When randomize=0: if start=1 -> RUN, else -> IDLE. seed_en drops in that same cycle.
- RUN:
  - running=1; divider clears on entry.
  - step_en pulses high for exactly one cycle every STEP_DIV cycles. The first pulse is on the STEP_DIV-th edge after entry, so with STEP_DIV=1 it pulses every cycle.
  - On each edge where step_en=1, evaluate grid_next:
    - gen_count += 1, saturating at all-ones.
    - If grid_next == 0: extinct=1 -> DONE.
    - Else if grid_next == grid_cur: stable=1 -> DONE.
    - Else if MAX_GEN != 0 and the new gen_count == MAX_GEN -> DONE.
  - start=0 -> IDLE with no further step; the divider is lost.
  - randomize=1 -> SEED.
  - If start drops on the same edge as a step, the step completes first, then the state goes to IDLE.
- DONE:
  - step_en=0; running=0; flags held.
  - randomize=1 -> SEED.
  - else start=0 -> IDLE; flags remain visible until the next SEED or RUN entry.
- Simultaneous randomize and start in any state: randomize wins.
- Reset mid-operation forces IDLE immediately:
  - step_en and seed_en drop asynchronously.
  - The LFSR returns to LFSR_SEED.
- seed is always driven with the current LFSR value. seed_en and step_en are never high together.

Test Plan:
- Reset: assert reset=0 mid-RUN -> step_en, running, gen_count, stable, extinct all 0 at once; seed = LFSR_SEED.
- Seed then run, STEP_DIV=1:
  - randomize=1 for 10 cycles -> seed_en high exactly 10 cycles, seed changes every cycle, never 0.
  - Then start=1 with a changing grid model -> step_en every cycle; gen_count = 50 after 50 cycles.
- Pacing: STEP_DIV=4, start=1 for 40 cycles -> step_en pulses 10 times, 4 cycles apart, first on the 4th edge; gen_count = 10.
- Stable: grid_cur = grid_next = 64'h0000_0000_1818_0000 (block), start=1 -> first step sets stable=1, gen_count=1, state DONE, no further step_en.
- Extinct: grid_cur = 64'h0000_0000_0010_0000, grid_next = 0 -> extinct=1, stable=0, DONE. Then randomize=1 -> flags and gen_count clear, seed_en=1.
- Limit and pause:
  - MAX_GEN=5, start=1 -> DONE after exactly 5 step_en pulses.
  - Separately, with MAX_GEN=0: start=0 after 3 steps, then start=1 -> count resumes 4,5,...
